mimc_hash_ctrl: RTL and testbench
=================================

Name: mimc_hash_ctrl

Overview:
- Sequencer that turns a stream of field elements into a single MiMC hash digest by chaining one shared multi-cycle MiMC cipher core.
- Chaining rule: acc <= E(acc + m_i mod p).
- Sits between a host-side valid/ready message port and the cipher core's en/done port, and owns the chaining accumulator.
- Adds modular reduction, a core watchdog and a digest output handshake.

Parameters:
- N_BITS, 254, width of field elements and the datapath.
- MODULUS, 254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001, field prime p. Requires 2^N_BITS < 2p.
- IV, 0, initial accumulator value. Requires IV < MODULUS.
- TIMEOUT_CYCLES, 4096, maximum cycles core_en may stay high without core_done.

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-low reset
- in_valid  input  1  message element valid
- in_ready  output  1  controller can accept an element
- in_data  input  N_BITS  message element, any value in [0, 2^N_BITS)
- in_last  input  1  element is the final one of the message
- digest_valid  output  1  digest available
- digest  output  N_BITS  hash result
- digest_ready  input  1  consumer accepts the digest
- core_en  output  1  start/hold request to the cipher core
- core_in  output  N_BITS  cipher core input
- core_out  input  N_BITS  cipher core output, valid while core_done=1
- core_done  input  1  cipher core result valid
- busy  output  1  high in any state except IDLE
- err_timeout  output  1  sticky watchdog error

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, acc=IV, last_q=0, wdog=0.
  - Outputs: in_ready=0 during reset, 1 from the first cycle after release; digest_valid=0; digest=0; core_en=0; core_in=0; busy=0; err_timeout=0.
- States: IDLE, ADD, RUN, DONE, ERR.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch m = (in_data>=MODULUS) ? in_data-MODULUS : in_data; latch last_q=in_last; go to ADD.
- ADD (1 cycle):
  - s = acc+m as an N_BITS+1 wide sum; core_in <= (s>=MODULUS) ? s-MODULUS : s.
  - Go to RUN.
- RUN:
  - core_en=1; core_in held stable.
  - wdog increments each cycle.
  - On core_done=1: acc <= core_out, core_en drops next cycle, wdog cleared. If last_q, go to DONE; else go to IDLE.
  - If wdog reaches TIMEOUT_CYCLES-1 with core_done=0: go to ERR, core_en=0.
  - core_done while not in RUN is ignored.
- DONE:
  - digest_valid=1; digest=acc, stable while waiting.
  - On digest_ready=1: digest_valid=0, acc <= IV, go to IDLE.
  - digest_ready while digest_valid=0 is ignored.
- ERR:
  - err_timeout=1; in_ready=0; core_en=0; digest_valid=0.
  - Exits only via reset.
- Latency:
  - Accept to core_en rise = 2 cycles.
  - core_done to in_ready (non-last element) = 1 cycle.
  - core_done to digest_valid (last element) = 1 cycle.
  - Throughput: one element per (core latency + 3) cycles.
- Boundaries:
  - in_data=MODULUS reduces to 0.
  - in_data=2^N_BITS-1 reduces by one subtraction.
  - acc+m=MODULUS gives core_in=0.
  - A single-element message (in_last on the first element) is legal.
  - in_ready=0 in ADD, RUN, DONE and ERR; no input is buffered.
- Reset mid-operation: everything returns to reset values immediately. Any partial message and digest are discarded, and core_en drops asynchronously.

Test Plan:
- Bench config: N_BITS=8, MODULUS=251, IV=0, TIMEOUT_CYCLES=16. Stub core returns (in*3) mod 251 after 4 cycles.
- Single element 5 with in_last=1 -> core_in=5, digest=15, digest_valid 1 cycle after core_done; in_ready stays 0 until digest_ready.
- Elements 5 then 7 with last on the 2nd -> 2nd core_in=(15+7)=22, digest=66; in_ready reasserts 1 cycle after the first core_done.
- in_data=250 then in_data=255 (last) -> first reduction gives 250, core_out=(750 mod 251)=248; second element reduces to 4, 248+4=252 -> core_in=1, digest=3.
- Stub core never asserts done -> core_en high exactly 16 cycles, then err_timeout=1 and core_en=0. in_valid is then ignored until reset.
- Drop rst during RUN -> core_en=0 in the same cycle. After release, the message 5 (last) yields digest=15, proving acc was restored to IV.
- digest_ready held low for 10 cycles in DONE -> digest_valid and digest stay stable. After the handshake, a new message 1 (last) yields digest=3.

Source files
------------

// File: rtl/mimc_hash_ctrl_if.sv
// mimc_hash_ctrl_if: message-in and digest-out handshakes between host and hash controller
interface mimc_hash_ctrl_if #(parameter int N_BITS = 254);
    logic              in_valid;
    logic              in_ready;
    logic [N_BITS-1:0] in_data;
    logic              in_last;
    logic              digest_valid;
    logic [N_BITS-1:0] digest;
    logic              digest_ready;
    modport master (output in_valid, in_data, in_last, digest_ready,
                    input  in_ready, digest_valid, digest);
    modport slave  (input  in_valid, in_data, in_last, digest_ready,
                    output in_ready, digest_valid, digest);
endinterface

// File: rtl/mimc_hash_ctrl.sv
// mimc_hash_ctrl: chains a shared multi-cycle MiMC core over a message, acc <= E(acc + m mod p)
module mimc_hash_ctrl #(
    parameter int                N_BITS         = 254,
    parameter logic [N_BITS-1:0] MODULUS        = 254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001,
    parameter logic [N_BITS-1:0] IV             = '0,
    parameter int                TIMEOUT_CYCLES = 4096
) (
    input  logic              clk,
    input  logic              rst,
    mimc_hash_ctrl_if.slave   bus,
    output logic              core_en,
    output logic [N_BITS-1:0] core_in,
    input  logic [N_BITS-1:0] core_out,
    input  logic              core_done,
    output logic              busy,
    output logic              err_timeout
);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, ADD, RUN, DONE, ERR} state_t;

    state_t            state, state_nx;
    logic [WW-1:0]     wdog;
    logic [N_BITS-1:0] acc, m, in_red, sum_red;
    logic [N_BITS:0]   sum;
    logic              last_q, accept, wdog_exp;

    // Since 2^N_BITS < 2p, a single conditional subtraction fully reduces any input or sum
    assign in_red   = (bus.in_data >= MODULUS) ? bus.in_data - MODULUS : bus.in_data;
    assign sum      = {1'b0, acc} + {1'b0, m};
    assign sum_red  = (sum >= {1'b0, MODULUS}) ? N_BITS'(sum - {1'b0, MODULUS}) : sum[N_BITS-1:0];
    assign accept   = bus.in_valid && bus.in_ready;
    assign wdog_exp = wdog == WW'(TIMEOUT_CYCLES - 1);

    // in_ready is gated by rst so it stays low while reset is held
    assign bus.in_ready     = rst && state == IDLE;
    assign bus.digest_valid = state == DONE;
    assign bus.digest       = (state == DONE) ? acc : '0;
    assign core_en          = state == RUN;
    assign busy             = state != IDLE;
    assign err_timeout      = state == ERR;

    // State register; reset asynchronously forces IDLE so core_en drops at once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // Next-state: done wins over the watchdog in the same cycle; ERR is only left via reset
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept ? ADD : IDLE;
            ADD:     state_nx = RUN;
            RUN:     state_nx = core_done ? (last_q ? DONE : IDLE) : (wdog_exp ? ERR : RUN);
            DONE:    state_nx = bus.digest_ready ? IDLE : DONE;
            default: state_nx = state;
        endcase
    end

    // Datapath: element latch, reduced core input, accumulator chaining and watchdog
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc     <= IV;
            m       <= '0;
            last_q  <= 1'b0;
            core_in <= '0;
            wdog    <= '0;
        end else begin
            if (state == IDLE && accept) begin
                m      <= in_red;
                last_q <= bus.in_last;
            end
            if (state == ADD) core_in <= sum_red;
            wdog <= (state == RUN && !core_done) ? wdog + 1'b1 : '0;
            if (state == RUN && core_done) acc <= core_out;
            if (state == DONE && bus.digest_ready) acc <= IV;
        end
    end
endmodule

// File: tb/tb_mimc_hash_ctrl.sv
// tb_mimc_hash_ctrl: scenario tasks plus randomized messages checked against an arithmetic hash model
module tb_mimc_hash_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       core_en, core_done, busy, err_timeout, hang;
    logic [7:0] core_in, core_out;
    int         checks = 0;
    int         errors = 0;
    int         scnt;

    mimc_hash_ctrl_if #(.N_BITS(8)) bus ();

    mimc_hash_ctrl #(.N_BITS(8), .MODULUS(8'd251), .IV(8'd0), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .bus(bus), .core_en(core_en), .core_in(core_in),
        .core_out(core_out), .core_done(core_done), .busy(busy), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    // Stub cipher core: (in*3) mod 251 after 4 enabled cycles, never answers while hang is set
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            scnt <= 0; core_done <= 1'b0; core_out <= 8'd0;
        end else if (core_done) begin
            core_done <= 1'b0; scnt <= 0;
        end else if (core_en && !hang) begin
            if (scnt == 3) begin
                core_done <= 1'b1;
                core_out  <= 8'((int'(core_in) * 3) % 251);
            end else scnt <= scnt + 1;
        end
    end

    // Reference: one chaining step of the hash over the field Z_251
    function automatic int step(input int acc, input int d);
        return (((acc + d % 251) % 251) * 3) % 251;
    endfunction

    task automatic push(input logic [7:0] d, input logic l, output logic ok);
        int n = 0;
        ok = 1'b1;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin @(negedge clk); n++; end
        if (!bus.in_ready) begin ok = 1'b0; return; end
        bus.in_valid = 1'b1; bus.in_data = d; bus.in_last = l;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Sends one element, reports core_in seen, cycles to core_en, and flags one cycle after core_done
    task automatic do_elem(input logic [7:0] d, input logic l, output logic [7:0] ci, output int lat,
                           output logic ra, output logic dva, output logic ok);
        int n = 0;
        ci = 'x; lat = 0; ra = 1'bx; dva = 1'bx;
        push(d, l, ok);
        if (!ok) return;
        while (!core_en && lat < 20) begin @(negedge clk); lat++; end
        if (!core_en) begin ok = 1'b0; return; end
        ci = core_in;
        while (!core_done && n < 40) begin @(negedge clk); n++; end
        if (!core_done) begin ok = 1'b0; return; end
        @(negedge clk);
        ra = bus.in_ready; dva = bus.digest_valid;
    endtask

    task automatic take_digest(input int hold, output logic [7:0] d, output logic st, output logic ok);
        int n = 0;
        ok = 1'b1; st = 1'b1; d = 'x;
        while (!bus.digest_valid && n < 40) begin @(negedge clk); n++; end
        if (!bus.digest_valid) begin ok = 1'b0; return; end
        d = bus.digest;
        repeat (hold) begin
            @(negedge clk);
            if (!bus.digest_valid || bus.digest !== d || bus.in_ready) st = 1'b0;
        end
        bus.digest_ready = 1'b1;
        @(negedge clk);
        bus.digest_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({bus.in_ready, bus.digest_valid, core_en, busy, err_timeout} !== 5'b0 || bus.digest !== 8'd0 || core_in !== 8'd0) begin
            errors++;
            $display("FAIL reset_outputs got rdy=%b dv=%b en=%b busy=%b err=%b dig=%0d ci=%0d exp all 0",
                     bus.in_ready, bus.digest_valid, core_en, busy, err_timeout, bus.digest, core_in);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %b exp 1", bus.in_ready); end
    endtask

    task automatic test_single();
        logic [7:0] ci, d; int lat; logic ra, dva, ok, st;
        do_elem(8'd5, 1'b1, ci, lat, ra, dva, ok);
        checks++;
        if (!ok || ci !== 8'd5) begin errors++; $display("FAIL single_core_in got %0d ok=%b exp 5", ci, ok); end
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL single_en_latency got %0d exp 1 cycle after ADD", lat); end
        checks++;
        if (dva !== 1'b1 || ra !== 1'b0) begin errors++; $display("FAIL single_after_done got dv=%b rdy=%b exp dv=1 rdy=0", dva, ra); end
        take_digest(0, d, st, ok);
        checks++;
        if (!ok || d !== 8'd15) begin errors++; $display("FAIL single_digest got %0d ok=%b exp 15", d, ok); end
        checks++;
        if (bus.in_ready !== 1'b1 || bus.digest_valid !== 1'b0) begin
            errors++; $display("FAIL single_release got rdy=%b dv=%b exp rdy=1 dv=0", bus.in_ready, bus.digest_valid);
        end
    endtask

    task automatic test_two();
        logic [7:0] ci, d; int lat; logic ra, dva, ok, st;
        do_elem(8'd5, 1'b0, ci, lat, ra, dva, ok);
        checks++;
        if (!ok || ra !== 1'b1 || dva !== 1'b0) begin errors++; $display("FAIL two_first_ready got rdy=%b dv=%b ok=%b exp rdy=1 dv=0", ra, dva, ok); end
        do_elem(8'd7, 1'b1, ci, lat, ra, dva, ok);
        checks++;
        if (!ok || ci !== 8'd22) begin errors++; $display("FAIL two_core_in got %0d exp 22", ci); end
        take_digest(0, d, st, ok);
        checks++;
        if (!ok || d !== 8'd66) begin errors++; $display("FAIL two_digest got %0d exp 66", d); end
    endtask

    task automatic test_reduce();
        logic [7:0] ci, ci2, d; int lat; logic ra, dva, ok, ok2, st;
        do_elem(8'd250, 1'b0, ci, lat, ra, dva, ok);
        do_elem(8'd255, 1'b1, ci2, lat, ra, dva, ok2);
        checks++;
        if (!ok || !ok2 || ci !== 8'd250 || ci2 !== 8'd1) begin errors++; $display("FAIL reduce_core_in got %0d,%0d exp 250,1", ci, ci2); end
        take_digest(0, d, st, ok);
        checks++;
        if (!ok || d !== 8'd3) begin errors++; $display("FAIL reduce_digest got %0d exp 3", d); end
        do_elem(8'd251, 1'b1, ci, lat, ra, dva, ok);
        take_digest(0, d, st, ok2);
        checks++;
        if (!ok || !ok2 || ci !== 8'd0 || d !== 8'd0) begin errors++; $display("FAIL modulus_input got ci=%0d dig=%0d exp 0,0", ci, d); end
        do_elem(8'd5, 1'b0, ci, lat, ra, dva, ok);
        do_elem(8'd236, 1'b1, ci, lat, ra, dva, ok2);
        checks++;
        if (!ok || !ok2 || ci !== 8'd0) begin errors++; $display("FAIL sum_equals_modulus got ci=%0d exp 0", ci); end
        take_digest(0, d, st, ok);
    endtask

    task automatic test_hold();
        logic [7:0] ci, d; int lat; logic ra, dva, ok, st;
        do_elem(8'd3, 1'b1, ci, lat, ra, dva, ok);
        take_digest(10, d, st, ok);
        checks++;
        if (!ok || !st || d !== 8'd9) begin errors++; $display("FAIL hold_digest got %0d stable=%b exp 9 stable=1", d, st); end
        do_elem(8'd1, 1'b1, ci, lat, ra, dva, ok);
        take_digest(0, d, st, ok);
        checks++;
        if (!ok || d !== 8'd3) begin errors++; $display("FAIL hold_next_digest got %0d exp 3", d); end
    endtask

    task automatic test_random();
        logic [7:0] ci, d; int lat, len, acc, x, exp_ci; logic ra, dva, ok, st;
        for (int k = 0; k < 8; k++) begin
            len = $urandom_range(1, 4);
            acc = 0;
            for (int i = 0; i < len; i++) begin
                x = $urandom_range(0, 255);
                exp_ci = (acc + x % 251) % 251;
                do_elem(8'(x), i == len - 1, ci, lat, ra, dva, ok);
                acc = step(acc, x);
                checks++;
                if (!ok || ci !== 8'(exp_ci) || ra !== (i != len - 1) || dva !== (i == len - 1)) begin
                    errors++;
                    $display("FAIL rand_elem msg%0d el%0d got ci=%0d rdy=%b dv=%b exp ci=%0d", k, i, ci, ra, dva, exp_ci);
                end
            end
            take_digest($urandom_range(0, 3), d, st, ok);
            checks++;
            if (!ok || !st || d !== 8'(acc)) begin errors++; $display("FAIL rand_digest msg%0d got %0d exp %0d", k, d, acc); end
        end
    endtask

    task automatic test_rst_mid();
        logic [7:0] ci, d; int n = 0, lat; logic ra, dva, ok, st;
        push(8'd5, 1'b0, ok);
        while (!core_en && n < 20) begin @(negedge clk); n++; end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (!ok || core_en !== 1'b0 || busy !== 1'b0 || bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL rst_mid got en=%b busy=%b rdy=%b exp 0,0,0", core_en, busy, bus.in_ready);
        end
        @(negedge clk);
        rst = 1'b1;
        do_elem(8'd5, 1'b1, ci, lat, ra, dva, ok);
        take_digest(0, d, st, ok);
        checks++;
        if (!ok || d !== 8'd15) begin errors++; $display("FAIL rst_mid_digest got %0d exp 15", d); end
    endtask

    task automatic test_timeout();
        int n = 0, cyc = 0; logic ok, stuck = 1'b1;
        hang = 1'b1;
        push(8'd9, 1'b1, ok);
        while (!core_en && n < 20) begin @(negedge clk); n++; end
        while (core_en && cyc < 40) begin cyc++; @(negedge clk); end
        checks++;
        if (!ok || cyc !== 16) begin errors++; $display("FAIL timeout_en_cycles got %0d exp 16", cyc); end
        checks++;
        if (err_timeout !== 1'b1 || core_en !== 1'b0) begin errors++; $display("FAIL timeout_err got err=%b en=%b exp 1,0", err_timeout, core_en); end
        hang = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 8'd4; bus.in_last = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (bus.in_ready || core_en || !err_timeout || !busy || bus.digest_valid) stuck = 1'b0;
        end
        bus.in_valid = 1'b0;
        checks++;
        if (!stuck) begin errors++; $display("FAIL timeout_sticky got left ERR exp stay in ERR"); end
        rst = 1'b0;
        #1;
        checks++;
        if (err_timeout !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL timeout_reset got err=%b busy=%b exp 0,0", err_timeout, busy); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1);
    end

    initial begin
        hang = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = 8'd0; bus.in_last = 1'b0; bus.digest_ready = 1'b0;
        test_reset();
        test_single();
        test_two();
        test_reduce();
        test_hold();
        test_random();
        test_rst_mid();
        test_timeout();
        test_single();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
